round_robin_arbiter: RTL and testbench



---
 rtl/round_robin_arbiter.sv | 129 ++++++++++++
 tb/tb_round_robin_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : Round-robin arbiter with one-hot rotating priority pointer and
//               a per-grant hold-time limit; drives shared-datapath selects.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ptr,
    output logic               busy,
    output logic               timeout
);

    localparam int c_CW = $clog2(HOLD_MAX + 1);
    localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_CW-1:0] c_HOLD_MAX = c_CW'(HOLD_MAX);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] r_ptr;
    logic [NUM_REQ-1:0] w_ptr_nxt;
    logic [c_CW-1:0]    r_hold;
    logic [c_CW-1:0]    w_hold_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;

    logic [c_IW-1:0]    w_ptr_idx;
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_first;
    logic [NUM_REQ-1:0] w_sel;
    logic               w_owner_drop;
    logic               w_expire;
    logic               w_release;

    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_ptr[i]) begin
                w_ptr_idx = c_IW'(i);
            end
        end
    end

    // Rotate requests so the pointer position lands on bit 0, isolate the
    // lowest set bit, then rotate the winner back into place.
    always_comb begin
        w_rot   = NUM_REQ'({req, req} >> w_ptr_idx);
        w_first = w_rot & (~w_rot + NUM_REQ'(1));
        w_sel   = NUM_REQ'(({w_first, w_first} << w_ptr_idx) >> NUM_REQ);
    end

    assign w_owner_drop = ~|(req & r_grant);
    assign w_expire     = (r_hold == c_HOLD_MAX);
    assign w_release    = done | w_owner_drop | w_expire;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= NUM_REQ'(1);
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_sel;
                    w_hold_nxt  = c_CW'(1);
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = '0;
                    w_hold_nxt    = '0;
                    w_ptr_nxt     = {r_grant[NUM_REQ-2:0], r_grant[NUM_REQ-1]};
                    w_timeout_nxt = w_expire & ~done & ~w_owner_drop;
                end else begin
                    w_hold_nxt = r_hold + c_CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        grant   = r_grant;
        ptr     = r_ptr;
        busy    = |r_grant;
        timeout = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_arbiter
// Description : Scoreboard bench for round_robin_arbiter using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [3:0] ptr;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] g;
        logic [3:0] p;
        logic       b;
        logic       t;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    round_robin_arbiter #(.NUM_REQ(4), .HOLD_MAX(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .ptr     (ptr),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        n_checks++;
        if (grant === e.g && ptr === e.p && busy === e.b && timeout === e.t) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grant=%b ptr=%b busy=%b timeout=%b, expected grant=%b ptr=%b busy=%b timeout=%b",
                     e.nm, grant, ptr, busy, timeout, e.g, e.p, e.b, e.t);
        end
    endtask

    // Inputs for the next edge; expectation describes outputs after that edge.
    task automatic step(input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic [3:0] ep,
                        input logic eb, input logic et, input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        req  = r;
        done = d;
        e.g = eg; e.p = ep; e.b = eb; e.t = et; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: checks one queued expectation per cycle, after the edge settles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                compare(sb_q.pop_front());
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        #12;
        e.g = 4'b0000; e.p = 4'b0001; e.b = 1'b0; e.t = 1'b0; e.nm = "reset_state";
        compare(e);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single requester
        step(4'b0010, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0, "single_grant");
        step(4'b0010, 1'b0, 4'b0010, 4'b0001, 1'b1, 1'b0, "single_hold");
        step(4'b0010, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, "single_release");
        step(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, "idle_hold");
        step(4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, "done_in_idle");

        // Asynchronous reset in the middle of a grant
        step(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, "pre_reset_grant");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        e.g = 4'b0000; e.p = 4'b0001; e.b = 1'b0; e.t = 1'b0; e.nm = "async_reset";
        compare(e);
        @(posedge clk);
        #2;
        reset = 1'b0;
        req   = 4'b0000;
        step(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, "post_reset_idle");

        // Fair rotation with all requesters active
        step(4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, "rot_g0");
        step(4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, "rot_r0");
        step(4'b1111, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, "rot_g1");
        step(4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, "rot_r1");
        step(4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, "rot_g2");
        step(4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, "rot_r2");
        step(4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, "rot_g3");
        step(4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, "rot_r3");
        step(4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, "rot_g0_again");
        step(4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, "rot_r0_again");

        // Move pointer to 1000, then check wrap-around priority
        step(4'b0100, 1'b0, 4'b0100, 4'b0010, 1'b1, 1'b0, "skip_to_2");
        step(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, "drop_release");
        step(4'b0011, 1'b0, 4'b0001, 4'b1000, 1'b1, 1'b0, "wrap_grant");
        step(4'b0011, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, "wrap_release");

        // Owner drops its request while others arrive
        step(4'b0001, 1'b0, 4'b0001, 4'b0010, 1'b1, 1'b0, "odrop_grant");
        step(4'b0110, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, "odrop_release");
        step(4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, "odrop_regrant");
        step(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, "odrop_done");

        // Hold-time expiry: grant visible exactly 8 cycles, then timeout pulse
        step(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, "to_grant");
        for (int i = 0; i < 7; i++)
            step(4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, "to_hold");
        step(4'b0100, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1, "to_expire");
        step(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, "to_clear");

        // Expiry coinciding with done: no timeout pulse
        step(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, "tod_grant");
        for (int i = 0; i < 7; i++)
            step(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, "tod_hold");
        step(4'b1000, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, "tod_release");
        step(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, "tod_idle");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
